// File: rtl/roi_pkg.sv
// rtl/roi_pkg.sv - shared constants and types for the ROI RAM reader
package roi_pkg;

    localparam int NUM_BANKS = 5;
    localparam int BG_BANK   = 4;
    localparam int PIX_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic [2:0]       bank;
        logic             last;
    } beat_t;

endpackage

// File: rtl/roi_skid_buf.sv
// rtl/roi_skid_buf.sv - 2-entry ready/valid beat buffer with pass-through and occupancy
module roi_skid_buf
    import roi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  beat_t      in_tdata,
    input  logic       in_tvalid,
    output beat_t      out_tdata,
    output logic       out_tvalid,
    input  logic       out_tready,
    output logic [1:0] occupancy
);

    beat_t mem [2];
    logic  rd_ptr;
    logic  wr_ptr;
    logic  push;
    logic  pop;

    // Oldest stored beat wins; an arriving beat passes straight through when nothing is stored
    always_comb begin
        out_tvalid = (occupancy != 2'd0) || in_tvalid;
        out_tdata  = '0;
        if (occupancy != 2'd0) begin
            out_tdata = mem[rd_ptr];
        end else if (in_tvalid) begin
            out_tdata = in_tdata;
        end
        pop  = (occupancy != 2'd0) && out_tready;
        push = in_tvalid && !((occupancy == 2'd0) && out_tready);
    end

    // Storage, pointers and occupancy; upstream credit keeps pushes away from a full buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_tdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/roi_ram_reader.sv
// rtl/roi_ram_reader.sv - ROI bank patch read sequencer; background bank 4 enabled by ROI_READER_BG_EN
module roi_ram_reader
    import roi_pkg::*;
#(
    parameter int WIDTH   = 14,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = PIX_W,
    parameter int ROI_W   = 128,
    parameter int ROI_H   = 128,
    parameter int PATCH_W = 8,
    parameter int PATCH_H = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_BANKS*WIDTH-1:0]    off_x,
    input  logic [NUM_BANKS*WIDTH-1:0]    off_y,
    output logic [NUM_BANKS*ADDR_W-1:0]   addr_a_5,
    output logic [NUM_BANKS-1:0]          re_5,
    input  logic [NUM_BANKS*DATA_W-1:0]   q_5,
    output logic [DATA_W-1:0]             pix_data,
    output logic [2:0]                    pix_bank,
    output logic                          pix_last,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

`ifdef ROI_READER_BG_EN
    localparam int LAST_BANK = BG_BANK;
`else
    localparam int LAST_BANK = BG_BANK - 1;
`endif
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROI_W - PATCH_W + 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base [NUM_BANKS];
    logic [ADDR_W-1:0] next_base;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        bank;
    logic [15:0]       row;
    logic [15:0]       col;
    logic              range_ok;
    logic              issue;
    logic              final_read;
    logic              accept_last;
    logic              inflight;
    logic [2:0]        inflight_bank;
    logic              inflight_last;
    beat_t             in_beat;
    beat_t             out_beat;
    logic [1:0]        occupancy;

    // Every enabled bank must keep its whole patch inside the ROI
    always_comb begin
        range_ok = 1'b1;
        for (int k = 0; k <= LAST_BANK; k++) begin
            if (int'(off_x[k*WIDTH +: WIDTH]) > ROI_W - PATCH_W) range_ok = 1'b0;
            if (int'(off_y[k*WIDTH +: WIDTH]) > ROI_H - PATCH_H) range_ok = 1'b0;
        end
    end

    // Position flags and the start address of the bank that follows the current one
    always_comb begin
        final_read  = (bank == 3'(LAST_BANK)) && (row == 16'(PATCH_H - 1)) && (col == 16'(PATCH_W - 1));
        accept_last = pix_valid && pix_ready && pix_last;
        next_base   = '0;
        for (int k = 1; k < NUM_BANKS; k++) begin
            if (bank == 3'(k - 1)) next_base = base[k];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and read credit: stored beats plus the read in flight stay below two
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start && range_ok) state_next = ISSUE;
            end
            ISSUE: begin
                issue = ({1'b0, occupancy} + {2'b00, inflight}) < 3'd2;
                if (issue && final_read) state_next = DRAIN;
            end
            DRAIN: begin
                if (accept_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Only the bank being walked sees its address; every other bank reads 0
    always_comb begin
        re_5     = '0;
        addr_a_5 = '0;
        busy     = (state != IDLE);
        for (int k = 0; k <= LAST_BANK; k++) begin
            if ((state == ISSUE) && (bank == 3'(k))) begin
                addr_a_5[k*ADDR_W +: ADDR_W] = addr;
                re_5[k]                      = issue;
            end
        end
    end

    // Patch walk: origins latched as bank bases at start, then +1, +row step, or next base
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_BANKS; k++) base[k] <= '0;
            addr <= '0;
            bank <= 3'd0;
            row  <= 16'd0;
            col  <= 16'd0;
        end else if (state == IDLE) begin
            if (start && range_ok) begin
                for (int k = 0; k < NUM_BANKS; k++) begin
                    base[k] <= ADDR_W'(int'(off_y[k*WIDTH +: WIDTH]) * ROI_W + int'(off_x[k*WIDTH +: WIDTH]));
                end
                addr <= ADDR_W'(int'(off_y[0 +: WIDTH]) * ROI_W + int'(off_x[0 +: WIDTH]));
                bank <= 3'd0;
                row  <= 16'd0;
                col  <= 16'd0;
            end
        end else if (issue) begin
            if (col == 16'(PATCH_W - 1)) begin
                col <= 16'd0;
                if (row == 16'(PATCH_H - 1)) begin
                    row <= 16'd0;
                    if (!final_read) begin
                        bank <= bank + 3'd1;
                        addr <= next_base;
                    end
                end else begin
                    row  <= row + 16'd1;
                    addr <= addr + ROW_STEP;
                end
            end else begin
                col  <= col + 16'd1;
                addr <= addr + 1'b1;
            end
        end
    end

    // Track the read whose data returns next cycle, plus the done and err pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_bank <= 3'd0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_bank <= bank;
            inflight_last <= issue && final_read;
            done          <= (state == DRAIN) && accept_last;
            err           <= (state == IDLE) && start && !range_ok;
        end
    end

    // Select the returning bank's data and tag it
    always_comb begin
        in_beat = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (inflight_bank == 3'(k)) in_beat.data = q_5[k*DATA_W +: DATA_W];
        end
        in_beat.bank = inflight_bank;
        in_beat.last = inflight_last;
    end

    roi_skid_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (in_beat),
        .in_tvalid  (inflight),
        .out_tdata  (out_beat),
        .out_tvalid (pix_valid),
        .out_tready (pix_ready),
        .occupancy  (occupancy)
    );

    assign pix_data = out_beat.data;
    assign pix_bank = out_beat.bank;
    assign pix_last = out_beat.last;

endmodule

// File: tb/tb_roi_ram_reader.sv
// tb/tb_roi_ram_reader.sv - self-checking bench for roi_ram_reader against a patch-walk model
module tb_roi_ram_reader;

    localparam int W  = 14;
    localparam int AW = 15;
    localparam int DW = 8;
`ifdef ROI_READER_BG_EN
    localparam int NB = 5;
    localparam bit BG = 1'b1;
`else
    localparam int NB = 4;
    localparam bit BG = 1'b0;
`endif
    localparam int NBEATS = NB * 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [5*W-1:0]  off_x;
    logic [5*W-1:0]  off_y;
    logic [5*AW-1:0] addr_a_5;
    logic [4:0]      re_5;
    logic [5*DW-1:0] q_5;
    logic [DW-1:0]   pix_data;
    logic [2:0]      pix_bank;
    logic            pix_last;
    logic            pix_valid;
    logic            pix_ready;
    logic            busy;
    logic            done;
    logic            err;

    roi_ram_reader dut (
        .clk(clk), .rst(rst), .start(start), .off_x(off_x), .off_y(off_y),
        .addr_a_5(addr_a_5), .re_5(re_5), .q_5(q_5),
        .pix_data(pix_data), .pix_bank(pix_bank), .pix_last(pix_last),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Bank RAMs: pattern q = addr[7:0] ^ bank one cycle after re, noise otherwise
    always @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            q_5[k*DW +: DW] <= re_5[k] ? (8'(addr_a_5[k*AW +: AW]) ^ 8'(k)) : 8'($urandom);
        end
    end

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] b;
        logic       l;
    } tb_beat_t;

    typedef struct {
        int bank;
        int x;
        int y;
        bit rnd;
        bit exp_err;
        int exp_first;
        int exp_last;
    } vec_t;

    int       total = 0;
    int       bad = 0;
    int       ox[5];
    int       oy[5];
    int       exp_addr_q[$];
    int       exp_bank_q[$];
    tb_beat_t exp_beat_q[$];
    int       outstanding;
    bit       prev_hold;
    tb_beat_t held;
    int       accepted;
    bit       rnd_ready;
    bit       start_next;
    int       first_addr[5];
    int       last_addr[5];
    vec_t     vecs[9];
    int       dc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pack_offsets();
        for (int k = 0; k < 5; k++) begin
            off_x[k*W +: W] = W'(ox[k]);
            off_y[k*W +: W] = W'(oy[k]);
        end
    endtask

    task automatic clear_model();
        exp_addr_q.delete();
        exp_bank_q.delete();
        exp_beat_q.delete();
        outstanding = 0;
        prev_hold   = 1'b0;
        accepted    = 0;
        for (int k = 0; k < 5; k++) begin
            first_addr[k] = -1;
            last_addr[k]  = -1;
        end
    endtask

    task automatic build_model();
        clear_model();
        for (int b = 0; b < NB; b++) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    int a;
                    tb_beat_t t;
                    a = (oy[b] + r) * 128 + ox[b] + c;
                    exp_addr_q.push_back(a);
                    exp_bank_q.push_back(b);
                    t.d = 8'(a) ^ 8'(b);
                    t.b = 3'(b);
                    t.l = (b == NB - 1) && (r == 7) && (c == 7);
                    exp_beat_q.push_back(t);
                end
            end
        end
    endtask

    task automatic observe();
        int       cur;
        logic     inact;
        tb_beat_t got;
        cur   = (exp_bank_q.size() > 0) ? exp_bank_q[0] : -1;
        inact = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k != cur) inact = inact | (|addr_a_5[k*AW +: AW]) | re_5[k];
        end
        chk("inactive_bank_zero", inact, 0);
        if (re_5 != 5'd0) begin
            chk("re_onehot", $countones(re_5), 1);
            chk("credit", outstanding < 2, 1);
            if (cur < 0) begin
                chk("extra_re", re_5, 0);
            end else begin
                chk("re_bank", re_5, 5'(1 << cur));
                chk("addr", addr_a_5[cur*AW +: AW], exp_addr_q[0]);
                if (first_addr[cur] < 0) first_addr[cur] = int'(addr_a_5[cur*AW +: AW]);
                last_addr[cur] = int'(addr_a_5[cur*AW +: AW]);
                void'(exp_addr_q.pop_front());
                void'(exp_bank_q.pop_front());
            end
        end
        got = {pix_data, pix_bank, pix_last};
        if (prev_hold) begin
            chk("hold_valid", pix_valid, 1);
            chk("hold_beat", got, held);
        end
        if (pix_valid && pix_ready) begin
            if (exp_beat_q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                chk("pix_data", pix_data, exp_beat_q[0].d);
                chk("pix_bank", pix_bank, exp_beat_q[0].b);
                chk("pix_last", pix_last, exp_beat_q[0].l);
                void'(exp_beat_q.pop_front());
            end
            accepted++;
        end
        outstanding = outstanding + ((re_5 != 5'd0) ? 1 : 0) - ((pix_valid && pix_ready) ? 1 : 0);
        prev_hold = pix_valid && !pix_ready;
        held      = got;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start     = start_next;
        pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        observe();
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_re"}, re_5, 0);
        chk({tag, "_addr"}, |addr_a_5, 0);
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_data"}, pix_data, 0);
        chk({tag, "_bank"}, pix_bank, 0);
        chk({tag, "_last"}, pix_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic run_req(input bit exp_err, input bit poke, output int done_cyc);
        int first_valid;
        done_cyc    = -1;
        first_valid = -1;
        pack_offsets();
        if (exp_err) clear_model();
        else         build_model();
        start_next = 1'b1;
        step();
        start_next = 1'b0;
        step();
        chk("err_pulse", err, exp_err);
        chk("busy_after_start", busy, !exp_err);
        if (exp_err) begin
            for (int i = 0; i < 3; i++) begin
                step();
                chk("rej_re", re_5, 0);
                chk("rej_busy", busy, 0);
                chk("rej_err_once", err, 0);
            end
            return;
        end
        chk("first_re", re_5 != 5'd0, 1);
        for (int cyc = 1; cyc < 4000 && done_cyc < 0; cyc++) begin
            start_next = poke && (cyc == 9);
            if (poke) off_x[0 +: W] = (cyc == 9) ? W'(121) : W'(ox[0]);
            step();
            if (first_valid < 0 && pix_valid) first_valid = cyc;
            chk("no_err_while_busy", err, 0);
            if (done) begin
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end else begin
                chk("busy_hold", busy, 1);
            end
        end
        start_next = 1'b0;
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        chk("beats_left", exp_beat_q.size(), 0);
        chk("addrs_left", exp_addr_q.size(), 0);
        if (!rnd_ready) begin
            chk("first_valid_cyc", first_valid, 1);
            chk("done_cyc", done_cyc, NBEATS + 1);
        end
        step();
        chk("done_single", done, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 0,     0,     1'b0, 1'b0, 0,     903};
        vecs[1] = '{2, 120,   120,   1'b0, 1'b0, 15480, 16383};
        vecs[2] = '{1, 121,   0,     1'b0, 1'b1, -1,    -1};
        vecs[3] = '{0, 0,     121,   1'b1, 1'b1, -1,    -1};
        vecs[4] = '{3, 120,   0,     1'b1, 1'b0, 120,   1023};
        vecs[5] = '{4, 500,   0,     1'b1, BG,   -1,    -1};
        vecs[6] = '{4, 37,    99,    1'b1, 1'b0, 12709, 13612};
        vecs[7] = '{1, 16383, 16383, 1'b1, 1'b1, -1,    -1};
        vecs[8] = '{0, 64,    3,     1'b1, 1'b0, 448,   1351};

        rst = 1'b1; start = 1'b0; start_next = 1'b0; pix_ready = 1'b0; rnd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin ox[k] = 0; oy[k] = 0; end
        pack_offsets();
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_chk("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < 5; k++) begin ox[k] = 0; oy[k] = 0; end
            ox[vecs[v].bank] = vecs[v].x;
            oy[vecs[v].bank] = vecs[v].y;
            rnd_ready = vecs[v].rnd;
            run_req(vecs[v].exp_err, 1'b0, dc);
            if (!vecs[v].exp_err && vecs[v].bank < NB && vecs[v].exp_first >= 0) begin
                chk("vec_first_addr", first_addr[vecs[v].bank], vecs[v].exp_first);
                chk("vec_last_addr", last_addr[vecs[v].bank], vecs[v].exp_last);
            end
        end

        rnd_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) begin
                ox[k] = $urandom_range(0, 120);
                oy[k] = $urandom_range(0, 120);
            end
            run_req(1'b0, r == 0, dc);
        end

        rnd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin ox[k] = 8 * k; oy[k] = 5 + k; end
        pack_offsets();
        build_model();
        start_next = 1'b1;
        step();
        start_next = 1'b0;
        for (int c = 0; c < 400 && accepted < 100; c++) step();
        chk("reached_beat_100", accepted, 100);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_chk("abort");
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        for (int k = 0; k < 5; k++) begin ox[k] = 100 - 3 * k; oy[k] = 17 * k; end
        run_req(1'b0, 1'b0, dc);
        chk("restart_first_addr", first_addr[0], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
